if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port imem_ack  input  1  memory returns data this cycle; may be same cycle as request.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack.
REQ-008 SHALL have port stall  input  1  IF/ID register cannot accept this cycle.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port out_valid  output  1  out_pc4/out_instr hold a fetched instruction.
REQ-012 SHALL have port out_pc4  output  32  address of fetched instruction + 4.
REQ-013 SHALL have port out_instr  output  32  fetched instruction.

Function
REQ-014 SHALL keep FSM states FETCH, HOLD, DISCARD plus registers pc, req_addr, output register, one-entry skid buffer.
REQ-015 SHALL define accept = out_valid && !stall; output register loadable when !out_valid or accept.
REQ-016 SHALL drive imem_req=1 in FETCH and DISCARD, 0 in HOLD; imem_addr=req_addr, stable while imem_req && !imem_ack.
REQ-017 FETCH, ack, output loadable: load out_pc4=req_addr+4, out_instr=imem_rdata, out_valid=1 next cycle; pc,req_addr advance by 4; stay FETCH.
REQ-018 FETCH, ack, output not loadable: capture word and req_addr+4 into skid buffer, advance pc, go HOLD.
REQ-019 HOLD: on accept move skid into output register (out_valid stays 1), go FETCH; otherwise remain, no request.
REQ-020 Latency: ack in cycle N gives out_valid in N+1; zero-wait memory with stall=0 sustains one instruction per cycle.
REQ-021 out_valid SHALL clear after accept when no new word loads the same cycle.
REQ-022 redirect SHALL take priority over every other event: next cycle out_valid=0, skid empty, pc=req_addr={redirect_pc[31:2],2'b00}.
REQ-023 redirect with imem_req=1 and imem_ack=0 SHALL go DISCARD, keeping old req_addr on the bus and target in pc until ack.
REQ-024 DISCARD: on ack drop data, set req_addr=pc, go FETCH; a further redirect in DISCARD overwrites pending target.
REQ-025 redirect in same cycle as ack SHALL drop that word and go FETCH at target; in HOLD SHALL go FETCH at target.
REQ-026 Address arithmetic SHALL be modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000, out_pc4=32'h0000_0000.
REQ-027 stall SHALL never lose or duplicate an instruction; each fetched, non-flushed word presented exactly once, in order.

Reset
REQ-028 rst=1 SHALL immediately force state FETCH, pc=req_addr=RESET_PC, out_valid=0, out_pc4=0, out_instr=0, skid empty, imem_req=0 while rst is high.
REQ-029 imem_req SHALL assert the first cycle after rst deasserts with imem_addr=RESET_PC.
REQ-030 Reset mid-request SHALL abandon the outstanding request; late ack after reset is treated as response to RESET_PC fetch only if imem_req=1.

Verification
REQ-031 Zero-wait memory, stall=0, RESET_PC=0: out_pc4 = 4,8,12,16 on consecutive cycles, out_instr matches memory words 0..3.
REQ-032 Two-cycle memory latency: ack every 3rd cycle -> out_valid pulses 1 cycle after each ack, addresses 0,4,8 in order.
REQ-033 stall=1 for 3 cycles with zero-wait memory: one word in output, one in skid, imem_req=0 in HOLD; on release words 8,12 delivered in order, none lost.
REQ-034 redirect to 32'h0000_0103 while request at 0x10 pending: imem_addr stays 0x10 until ack, data dropped, next fetch 0x100, out_valid=0 until 0x100 word returns.
REQ-035 pc=32'hFFFF_FFFC fetch: out_pc4=0, next imem_addr=0.
REQ-036 rst pulsed while in HOLD with out_valid=1: out_valid=0 immediately, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: drives the instruction memory and feeds the IF/ID register.
// A one-entry skid buffer keeps a word that returns while the IF/ID register is stalled.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc4,
   output logic [31:0] out_instr
);

   // HOLD means the skid buffer is full; no separate valid flag is kept for it.
   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic [31:0] skid_pc4;
   logic [31:0] skid_instr;

   logic        accept;
   logic        loadable;
   logic        got_word;
   logic [31:0] target;

   assign accept   = out_valid && !stall;
   assign loadable = !out_valid || accept;
   assign got_word = imem_req && imem_ack;
   assign target   = {redirect_pc[31:2], 2'b00};

   // Gated by rst so the request drops the instant reset asserts.
   assign imem_req  = !rst && (state != HOLD);
   assign imem_addr = req_addr;

   // NOTE: sequential state uses non-blocking assignments only, so every branch
   // below reads the values from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         out_valid  <= 1'b0;
         out_pc4    <= 32'h0;
         out_instr  <= 32'h0;
         skid_pc4   <= 32'h0;
         skid_instr <= 32'h0;
      end else if (redirect) begin
         out_valid <= 1'b0;
         pc        <= target;
         // A request already on the bus must complete before the target is issued.
         if (imem_req && !imem_ack) begin
            state <= DISCARD;
         end else begin
            state    <= FETCH;
            req_addr <= target;
         end
      end else begin
         case (state)
            FETCH: begin
               if (got_word) begin
                  pc       <= pc + 32'd4;
                  req_addr <= req_addr + 32'd4;
                  if (loadable) begin
                     out_valid <= 1'b1;
                     out_pc4   <= req_addr + 32'd4;
                     out_instr <= imem_rdata;
                  end else begin
                     skid_pc4   <= req_addr + 32'd4;
                     skid_instr <= imem_rdata;
                     state      <= HOLD;
                  end
               end else if (accept) begin
                  out_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (accept) begin
                  out_pc4   <= skid_pc4;
                  out_instr <= skid_instr;
                  state     <= FETCH;
               end
            end
            DISCARD: begin
               if (accept) out_valid <= 1'b0;
               if (got_word) begin
                  req_addr <= pc;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
